// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//
// Arbitrates the single register-file write port between the pipeline
// writeback stage (wb) and long-latency units (aux: mult/div, load return).
// Aux writes are buffered in a 2-entry FIFO; pipeline writes are never
// buffered. The pipeline normally wins, but a buffered aux entry that has
// lost arbitration STARVE_LIMIT times in a row is granted next, so aux
// results cannot be stalled forever. The winning write is registered onto
// the rf_* outputs for exactly one cycle. Writes to r0 are consumed but
// never enable the register file.
//
// Ports:
//   clk          sole clock, rising edge
//   reset_n      asynchronous active-low reset
//   wb_valid     pipeline writeback request
//   wb_rd        pipeline destination register
//   wb_data      pipeline writeback value
//   wb_ready     pipeline request granted this cycle (combinational)
//   aux_valid    aux write request
//   aux_rd       aux destination register
//   aux_data     aux writeback value
//   aux_ready    aux request accepted into the FIFO this cycle
//   rf_we        register-file write enable (registered)
//   rf_waddr     register-file write address (registered, holds when idle)
//   rf_wdata     register-file write data (registered, holds when idle)
//   aux_pending  FIFO non-empty, for hazard stall logic (registered state)

module regfile_write_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        wb_ready,
  input  logic        aux_valid,
  input  logic [4:0]  aux_rd,
  input  logic [31:0] aux_data,
  output logic        aux_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        aux_pending
);

  localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

  // FIFO entry layout: {rd[4:0], data[31:0]}
  logic [36:0] mem_q [2];
  logic [36:0] mem_d [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;
  logic [2:0]  starve_q, starve_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_waddr_q, rf_waddr_d;
  logic [31:0] rf_wdata_q, rf_wdata_d;

  logic        fifo_full;
  logic        head_valid;
  logic        push;
  logic        grant_head;
  logic        grant_wb;
  logic [36:0] head_entry;
  logic [4:0]  head_rd;
  logic [31:0] head_data;

  // Arbitration looks only at the registered FIFO count, so an entry pushed
  // this cycle cannot be granted until the next one. aux_ready depends on
  // fullness alone, not on a same-cycle pop, to keep it off the grant path.
  // Both ready outputs are forced low while reset is asserted.
  always_comb begin
    fifo_full  = (count_q == 2'd2);
    head_valid = (count_q != 2'd0);
    head_entry = mem_q[rd_ptr_q];
    head_rd    = head_entry[36:32];
    head_data  = head_entry[31:0];

    aux_ready  = reset_n && !fifo_full;
    push       = aux_valid && aux_ready;
    grant_head = head_valid && (!wb_valid || (starve_q == STARVE_MAX));
    grant_wb   = wb_valid && !grant_head;
    wb_ready   = reset_n && grant_wb;
  end

  // FIFO bookkeeping: push writes at wr_ptr, a head grant pops at rd_ptr.
  // Push is impossible when full and pop impossible when empty, so the
  // 2-bit count can neither overflow nor underflow.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = {aux_rd, aux_data};
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (grant_head) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, push} - {1'b0, grant_head};
  end

  // Starve counter: counts consecutive lost arbitrations of a waiting head;
  // cleared by a head grant or an empty FIFO, saturating at the limit.
  always_comb begin
    starve_d = starve_q;
    if (grant_head || !head_valid) begin
      starve_d = 3'd0;
    end else if (starve_q != STARVE_MAX) begin
      starve_d = starve_q + 3'd1;
    end
  end

  // Output register: the granted write appears one cycle after the grant.
  // A grant to r0 completes the handshake but leaves rf_we low, and
  // address/data only move when a real write is issued.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (grant_head) begin
      if (head_rd != 5'd0) begin
        rf_we_d    = 1'b1;
        rf_waddr_d = head_rd;
        rf_wdata_d = head_data;
      end
    end else if (grant_wb) begin
      if (wb_rd != 5'd0) begin
        rf_we_d    = 1'b1;
        rf_waddr_d = wb_rd;
        rf_wdata_d = wb_data;
      end
    end
  end

  // Control and output state, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      starve_q   <= 3'd0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= 32'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // FIFO storage needs no reset: entries are only read when count says so.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rf_we       = rf_we_q;
  assign rf_waddr    = rf_waddr_q;
  assign rf_wdata    = rf_wdata_q;
  assign aux_pending = (count_q != 2'd0);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter
//
// Directed bench for regfile_write_arbiter with STARVE_LIMIT = 3. Each table
// row is one clock cycle: inputs are driven just after a rising edge, and at
// the following falling edge the combinational ready outputs (for this
// cycle's inputs) and the registered outputs (reflecting the previous
// cycle's grant) are compared with hand-computed values. Reset behaviour is
// covered by hand-written sequences before and after the table.

module tb_regfile_write_arbiter;

  typedef struct {
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        aux_valid;
    logic [4:0]  aux_rd;
    logic [31:0] aux_data;
    logic        exp_wb_ready;
    logic        exp_aux_ready;
    logic        exp_rf_we;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
    logic        exp_pending;
  } vec_t;

  localparam int NUM_VECS = 31;

  logic        clk;
  logic        reset_n;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_ready;
  logic        aux_valid;
  logic [4:0]  aux_rd;
  logic [31:0] aux_data;
  logic        aux_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        aux_pending;

  int checks = 0;
  int errors = 0;
  vec_t vecs [NUM_VECS];

  regfile_write_arbiter #(.STARVE_LIMIT(3)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .wb_ready    (wb_ready),
    .aux_valid   (aux_valid),
    .aux_rd      (aux_rd),
    .aux_data    (aux_data),
    .aux_ready   (aux_ready),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .aux_pending (aux_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic wbv, input logic [4:0] wbrd, input logic [31:0] wbd,
    input logic auxv, input logic [4:0] auxrd, input logic [31:0] auxd,
    input logic ewbr, input logic eauxr, input logic ewe,
    input logic [4:0] ewa, input logic [31:0] ewd, input logic epend);
    vec_t v;
    v.wb_valid      = wbv;
    v.wb_rd         = wbrd;
    v.wb_data       = wbd;
    v.aux_valid     = auxv;
    v.aux_rd        = auxrd;
    v.aux_data      = auxd;
    v.exp_wb_ready  = ewbr;
    v.exp_aux_ready = eauxr;
    v.exp_rf_we     = ewe;
    v.exp_waddr     = ewa;
    v.exp_wdata     = ewd;
    v.exp_pending   = epend;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    wb_valid  = v.wb_valid;
    wb_rd     = v.wb_rd;
    wb_data   = v.wb_data;
    aux_valid = v.aux_valid;
    aux_rd    = v.aux_rd;
    aux_data  = v.aux_data;
  endtask

  task automatic checkOutput(input string name, input int tag,
                             input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s (step %0d): got 0x%08h, expected 0x%08h",
               name, tag, act, exp);
    end
  endtask

  task automatic idle();
    wb_valid  = 1'b0;
    wb_rd     = 5'd0;
    wb_data   = 32'd0;
    aux_valid = 1'b0;
    aux_rd    = 5'd0;
    aux_data  = 32'd0;
  endtask

  initial begin
    // Columns: wb_valid wb_rd wb_data | aux_valid aux_rd aux_data |
    //          wb_ready aux_ready rf_we rf_waddr rf_wdata aux_pending
    // wb-only write
    vecs[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,            1, 1, 0, 0,  32'h0,        0);
    vecs[1]  = mk(0, 0, 0,            0, 0, 0,            0, 1, 1, 5,  32'hDEADBEEF, 0);
    vecs[2]  = mk(0, 0, 0,            0, 0, 0,            0, 1, 0, 5,  32'hDEADBEEF, 0);
    // aux-only write: push, grant, output
    vecs[3]  = mk(0, 0, 0,            1, 7, 32'h12345678, 0, 1, 0, 5,  32'hDEADBEEF, 0);
    vecs[4]  = mk(0, 0, 0,            0, 0, 0,            0, 1, 0, 5,  32'hDEADBEEF, 1);
    vecs[5]  = mk(0, 0, 0,            0, 0, 0,            0, 1, 1, 7,  32'h12345678, 0);
    // starvation: wb continuous, one aux entry rd=9
    vecs[6]  = mk(1, 1, 32'h11,       1, 9, 32'h99,       1, 1, 0, 7,  32'h12345678, 0);
    vecs[7]  = mk(1, 2, 32'h22,       0, 0, 0,            1, 1, 1, 1,  32'h11,       1);
    vecs[8]  = mk(1, 3, 32'h33,       0, 0, 0,            1, 1, 1, 2,  32'h22,       1);
    vecs[9]  = mk(1, 4, 32'h44,       0, 0, 0,            1, 1, 1, 3,  32'h33,       1);
    vecs[10] = mk(1, 5, 32'h55,       0, 0, 0,            0, 1, 1, 4,  32'h44,       1);
    vecs[11] = mk(1, 5, 32'h55,       0, 0, 0,            1, 1, 1, 9,  32'h99,       0);
    vecs[12] = mk(0, 0, 0,            0, 0, 0,            0, 1, 1, 5,  32'h55,       0);
    // FIFO full with wb busy; order of aux writes 11,13,15 preserved
    vecs[13] = mk(1, 10, 32'hA0,      1, 11, 32'hB1,      1, 1, 0, 5,  32'h55,       0);
    vecs[14] = mk(1, 12, 32'hA1,      1, 13, 32'hB2,      1, 1, 1, 10, 32'hA0,       1);
    vecs[15] = mk(1, 14, 32'hA2,      1, 15, 32'hB3,      1, 0, 1, 12, 32'hA1,       1);
    vecs[16] = mk(1, 16, 32'hA3,      1, 15, 32'hB3,      1, 0, 1, 14, 32'hA2,       1);
    vecs[17] = mk(1, 17, 32'hA4,      1, 15, 32'hB3,      0, 0, 1, 16, 32'hA3,       1);
    vecs[18] = mk(1, 17, 32'hA4,      1, 15, 32'hB3,      1, 1, 1, 11, 32'hB1,       1);
    vecs[19] = mk(0, 0, 0,            0, 0, 0,            0, 0, 1, 17, 32'hA4,       1);
    vecs[20] = mk(0, 0, 0,            0, 0, 0,            0, 1, 1, 13, 32'hB2,       1);
    vecs[21] = mk(0, 0, 0,            0, 0, 0,            0, 1, 1, 15, 32'hB3,       0);
    // r0 writes from both sources are consumed without rf_we
    vecs[22] = mk(1, 0, 32'hFFFFFFFF, 0, 0, 0,            1, 1, 0, 15, 32'hB3,       0);
    vecs[23] = mk(0, 0, 0,            0, 0, 0,            0, 1, 0, 15, 32'hB3,       0);
    vecs[24] = mk(0, 0, 0,            1, 0, 32'hCAFE,     0, 1, 0, 15, 32'hB3,       0);
    vecs[25] = mk(0, 0, 0,            0, 0, 0,            0, 1, 0, 15, 32'hB3,       1);
    vecs[26] = mk(0, 0, 0,            0, 0, 0,            0, 1, 0, 15, 32'hB3,       0);
    // same-rd conflict: wb wins first, then the buffered aux write follows
    vecs[27] = mk(0, 0, 0,            1, 6, 32'h600,      0, 1, 0, 15, 32'hB3,       0);
    vecs[28] = mk(1, 6, 32'h601,      0, 0, 0,            1, 1, 0, 15, 32'hB3,       1);
    vecs[29] = mk(0, 0, 0,            0, 0, 0,            0, 1, 1, 6,  32'h601,      1);
    vecs[30] = mk(0, 0, 0,            0, 0, 0,            0, 1, 1, 6,  32'h600,      0);

    // Reset state, with requests raised to show both readies held low.
    reset_n   = 1'b0;
    idle();
    wb_valid  = 1'b1;
    wb_rd     = 5'd3;
    aux_valid = 1'b1;
    aux_rd    = 5'd4;
    #2;
    checkOutput("reset_rf_we",      -1, 32'(rf_we),       32'd0);
    checkOutput("reset_rf_waddr",   -1, 32'(rf_waddr),    32'd0);
    checkOutput("reset_rf_wdata",   -1, rf_wdata,         32'd0);
    checkOutput("reset_pending",    -1, 32'(aux_pending), 32'd0);
    checkOutput("reset_wb_ready",   -1, 32'(wb_ready),    32'd0);
    checkOutput("reset_aux_ready",  -1, 32'(aux_ready),   32'd0);
    idle();
    @(posedge clk);
    @(posedge clk);
    #2;
    reset_n = 1'b1;

    // Table-driven cycles.
    for (int i = 0; i < NUM_VECS; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput("wb_ready",    i, 32'(wb_ready),    32'(vecs[i].exp_wb_ready));
      checkOutput("aux_ready",   i, 32'(aux_ready),   32'(vecs[i].exp_aux_ready));
      checkOutput("rf_we",       i, 32'(rf_we),       32'(vecs[i].exp_rf_we));
      checkOutput("rf_waddr",    i, 32'(rf_waddr),    32'(vecs[i].exp_waddr));
      checkOutput("rf_wdata",    i, rf_wdata,         vecs[i].exp_wdata);
      checkOutput("aux_pending", i, 32'(aux_pending), 32'(vecs[i].exp_pending));
      @(posedge clk);
      #1;
    end

    // Reset mid-operation: fill the FIFO with two entries behind a busy wb.
    wb_valid  = 1'b1; wb_rd = 5'd20; wb_data = 32'h20;
    aux_valid = 1'b1; aux_rd = 5'd21; aux_data = 32'h21;
    @(negedge clk);
    checkOutput("mid_push1_ready", 100, 32'(aux_ready), 32'd1);
    @(posedge clk);
    #1;
    aux_rd = 5'd22; aux_data = 32'h22;
    @(negedge clk);
    checkOutput("mid_push2_ready", 101, 32'(aux_ready), 32'd1);
    @(posedge clk);
    #1;
    aux_valid = 1'b0;
    @(negedge clk);
    checkOutput("mid_full_pending", 102, 32'(aux_pending), 32'd1);
    checkOutput("mid_full_aready",  102, 32'(aux_ready),   32'd0);
    checkOutput("mid_rf_we_before", 102, 32'(rf_we),       32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_rst_rf_we",    103, 32'(rf_we),       32'd0);
    checkOutput("async_rst_pending",  103, 32'(aux_pending), 32'd0);
    checkOutput("async_rst_wb_ready", 103, 32'(wb_ready),    32'd0);
    checkOutput("async_rst_waddr",    103, 32'(rf_waddr),    32'd0);
    idle();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      checkOutput("post_rst_rf_we",   200 + k, 32'(rf_we),       32'd0);
      checkOutput("post_rst_pending", 200 + k, 32'(aux_pending), 32'd0);
      checkOutput("post_rst_ready",   200 + k, 32'(aux_ready),   32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 3: max consecutive cycles a buffered aux write may lose arbitration (legal range 1..7).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 wb_valid  input  1  pipeline writeback request (mem_wb stage).
REQ-005 wb_rd  input  5  pipeline destination register.
REQ-006 wb_data  input  32  pipeline writeback value.
REQ-007 wb_ready  output  1  pipeline request granted this cycle (combinational).
REQ-008 aux_valid  input  1  long-latency unit (mult/div, load return) write request.
REQ-009 aux_rd  input  5  aux destination register.
REQ-010 aux_data  input  32  aux writeback value.
REQ-011 aux_ready  output  1  aux request accepted into buffer this cycle.
REQ-012 rf_we  output  1  register-file write enable, registered.
REQ-013 rf_waddr  output  5  register-file write address, registered.
REQ-014 rf_wdata  output  32  register-file write data, registered.
REQ-015 aux_pending  output  1  aux buffer non-empty (for hazard stall logic).

Function
REQ-016 Aux requests SHALL enter a 2-entry FIFO; aux transfer occurs when aux_valid && aux_ready; aux_ready = !full, independent of a same-cycle pop.
REQ-017 A pushed entry SHALL NOT be arbitrated in its push cycle; minimum aux latency = push cycle + 1 grant cycle + 1 output register cycle.
REQ-018 Arbitration candidates each cycle: wb (if wb_valid) and FIFO head (if non-empty); at most one grant per cycle.
REQ-019 Default priority: wb wins; FIFO head granted only when wb_valid=0 or starve counter == STARVE_LIMIT.
REQ-020 Starve counter (3-bit): increments when FIFO non-empty and head not granted; clears to 0 on head grant or when FIFO empty; saturates at STARVE_LIMIT.
REQ-021 When counter == STARVE_LIMIT and wb_valid=1, head SHALL be granted and wb_ready=0 that cycle.
REQ-022 wb_ready = wb_valid && wb granted; wb has no buffer and SHALL hold request until wb_ready=1.
REQ-023 Granted request SHALL appear on rf_we/rf_waddr/rf_wdata at the next rising edge, held exactly one cycle; rf_we=0 in cycles following no grant.
REQ-024 Grant with rd==0 SHALL complete the handshake/pop but drive rf_we=0 (r0 hard-wired zero).
REQ-025 Same-rd conflict (wb_rd == head rd, both valid): normal priority applies; both writes issue in grant order, no merging or dropping.
REQ-026 FIFO order SHALL be strict FIFO; wrap-around of 1-bit read/write pointers with extra full/empty tracking; no overflow or underflow under any input.
REQ-027 rf_waddr/rf_wdata SHALL hold last value when rf_we=0.
REQ-028 aux_pending = FIFO count != 0, registered state.

Reset
REQ-029 reset_n low SHALL immediately clear FIFO (count 0), starve counter 0, rf_we 0, rf_waddr 0, rf_wdata 0.
REQ-030 During reset aux_ready=0 and wb_ready=0; FIFO contents in flight mid-operation are discarded.
REQ-031 First push accepted on first rising edge with reset_n high.

Verification
REQ-032 wb only: wb_valid=1, rd=5, data=0xDEADBEEF at cycle 0 -> wb_ready=1 cycle 0; rf_we=1, waddr=5, wdata=0xDEADBEEF cycle 1 only.
REQ-033 aux only: push rd=7, data=0x12345678 cycle 0, wb idle -> head granted cycle 1, rf_we=1 waddr=7 cycle 2, aux_pending 1 in cycle 1 only.
REQ-034 Starvation: wb_valid=1 continuously (rd=1..), one aux entry rd=9 pushed cycle 0 -> wb granted cycles 1-3, head granted cycle 4 with wb_ready=0, rf waddr=9 cycle 5, wb resumes cycle 5.
REQ-035 Full: three consecutive aux pushes with wb_valid=1 -> aux_ready=0 on third attempt while count=2; pop then accept on following cycle; order rf writes 1st,2nd,3rd preserved.
REQ-036 r0: wb rd=0 data=0xFFFFFFFF -> wb_ready=1, rf_we stays 0.
REQ-037 Reset mid-operation: FIFO holding 2 entries, reset_n low for 1 cycle asynchronously -> rf_we=0 and aux_pending=0 immediately, no stale entry ever written after release.
